nrdiv_top: RTL and testbench
============================

Name: nrdiv_top

Overview:
- Sequential non-restoring integer divider. It is the inverse operation of the team's Booth multiplier and uses the same controller/datapath split and the same serial operand loading over a shared data_in bus.
- Loads the dividend, then the divisor, and iterates one quotient bit per clock.
- Presents quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit and is driven by the same sequencer.

Parameters:
- WIDTH, 16, operand/result width in bits (minimum 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- data_in  input  WIDTH  dividend in the start cycle, divisor in the following cycle
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse, results valid
- div_by_zero  output  1  set with done when divisor == 0; held until next start
- quotient  output  WIDTH  result; held until next start
- remainder  output  WIDTH  result; held until next start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; A, Q, M, count, quotient, remainder cleared to 0.
  - busy=0, done=0, div_by_zero=0.
  - Reset mid-operation aborts immediately; no partial results are exposed.
- Registers:
  - A is WIDTH+1 bits, signed partial remainder.
  - Q is WIDTH bits, holding the dividend and then the quotient.
  - M is WIDTH+1 bits, zero-extended divisor.
  - count is clog2(WIDTH+1) bits.
- FSM states: IDLE, LOAD_M, ITER, FIX, DONE.
- IDLE, start=1 in cycle T:
  - Q<=data_in, A<=0, count<=WIDTH.
  - Clear quotient, remainder and div_by_zero.
  - Next state LOAD_M.
- LOAD_M (cycle T+1): M<=data_in.
  - If data_in==0: quotient<=all ones, remainder<=Q (dividend), div_by_zero<=1, next state DONE.
  - Otherwise: next state ITER.
- ITER, one cycle per bit (T+2 .. T+1+WIDTH):
  - Shift {A,Q} left by 1.
  - If the old A sign bit is 0, A<=shifted A − M; otherwise A<=shifted A + M.
  - Q[0]<=~(new A sign bit).
  - count decrements; after the iteration where count==1, next state FIX.
- FIX (T+2+WIDTH):
  - If A is negative, A<=A+M.
  - quotient<=Q, remainder<=A[WIDTH-1:0].
  - Next state DONE.
- DONE (T+3+WIDTH for a normal divide, T+2 for divide-by-zero):
  - done=1 for exactly this cycle; next state IDLE.
- busy is 1 from T+1 through the DONE cycle.
- start while busy is ignored: no restart, no error.
- data_in is ignored outside the start cycle and the LOAD_M cycle.
- Back-to-back operation: start may be asserted in the cycle after DONE (IDLE); minimum period is WIDTH+4 cycles.
- Unsigned arithmetic; the invariant dividend == quotient*divisor + remainder with remainder < divisor holds for every nonzero divisor.
- Dividend 0 gives quotient 0, remainder 0.
- A divisor larger than the dividend gives quotient 0, remainder = dividend.

Optional Feature:
- Macro: NRDIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - LOAD_M and IDLE store absolute values and latch the dividend and divisor signs.
  - FIX negates the quotient if the signs differ, and negates the remainder if the dividend is negative (truncation toward zero).
  - Latency is unchanged.
  - Divide-by-zero still returns all-ones and the original dividend.
  - Most-negative / −1 returns quotient = most-negative and remainder = 0.
- Undefined: unsigned only, as described above.

Decomposition:
- Package nrdiv_pkg: state enum (IDLE, LOAD_M, ITER, FIX, DONE) and the default WIDTH constant.
- Sub-module nrdiv_ctrl: the FSM and counter, driving load/shift/addsub/fix control strobes into datapath logic kept in nrdiv_top.

Test Plan:
- 100 / 7, start at T → done pulse at T+19, quotient=14, remainder=2, div_by_zero=0; busy high T+1..T+19.
- 0xFFFF / 1 → quotient=0xFFFF, remainder=0. Then immediately 3 / 10 (start in the cycle after done) → quotient=0, remainder=3.
- 5 / 0 → done at T+2, div_by_zero=1, quotient=0xFFFF, remainder=5. Next 9 / 3 clears the flag and returns quotient=3, remainder=0.
- start pulsed again during ITER with different data_in → ignored; first result 1000 / 33 → quotient=30, remainder=10.
- rst_n low for 1 cycle mid-ITER → all outputs 0 asynchronously, state IDLE. A fresh 50 / 6 then yields quotient=8, remainder=2.
- NRDIV_SIGNED_EN: −7 / 2 → quotient=−3 (0xFFFD), remainder=−1 (0xFFFF). 7 / −2 → quotient=−3, remainder=1.

Source files
------------

// File: rtl/nrdiv_pkg.sv
// nrdiv_pkg: shared FSM state type and default width for the non-restoring divider
package nrdiv_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [2:0] {IDLE, LOAD_M, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/nrdiv_ctrl.sv
// nrdiv_ctrl: divider FSM and iteration counter driving datapath strobes
//   clk, rst_n        clock, async active-low reset
//   start             begin operation (honoured in IDLE only)
//   m_zero            divisor on data_in is zero (meaningful in LOAD_M)
//   load/load_m       capture dividend / divisor strobes
//   shift/fix         one quotient-bit iteration / final correction strobes
//   busy, done        registered status outputs
module nrdiv_ctrl
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic m_zero,
  output logic load,
  output logic load_m,
  output logic shift,
  output logic fix,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] count;
  assign load   = state == IDLE && start;
  assign load_m = state == LOAD_M;
  assign shift  = state == ITER;
  assign fix    = state == FIX;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD_M;
          count <= CW'(WIDTH);
          busy  <= 1'b1;
        end
        LOAD_M: begin
          state <= m_zero ? DONE : ITER;
          done  <= m_zero;
        end
        ITER: begin
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/nrdiv_top.sv
// nrdiv_top: sequential non-restoring divider, one quotient bit per clock
//   clk, rst_n      clock, async active-low reset
//   start, data_in  dividend with start, divisor the next cycle
//   busy, done      status; done pulses one cycle with valid results
//   div_by_zero     set with done on a zero divisor
//   quotient, remainder  results, held until next start
//   Optional macro NRDIV_SIGNED_EN: two's complement operands, truncating division
module nrdiv_top
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic load, load_m, shift, fix, m_zero;
  logic [WIDTH:0] a, m, a_sh, a_nx, a_fx;
  logic [WIDTH-1:0] q, din_abs, q_res, r_res, dvd;
  assign m_zero = data_in == '0;
  assign a_sh = {a[WIDTH-1:0], q[WIDTH-1]};
  // Non-restoring step: sign of A picks subtract or add-back
  assign a_nx = a[WIDTH] ? a_sh + m : a_sh - m;
  assign a_fx = a[WIDTH] ? a + m : a;
`ifdef NRDIV_SIGNED_EN
  logic sd, sm;
  assign din_abs = data_in[WIDTH-1] ? -data_in : data_in;
  assign q_res = (sd ^ sm) ? -q : q;
  assign r_res = sd ? -a_fx[WIDTH-1:0] : a_fx[WIDTH-1:0];
  // Re-negating |dividend| recovers the original, including the most-negative value
  assign dvd = sd ? -q : q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd <= 1'b0;
      sm <= 1'b0;
    end else begin
      if (load) sd <= data_in[WIDTH-1];
      if (load_m) sm <= data_in[WIDTH-1];
    end
  end
`else
  assign din_abs = data_in;
  assign q_res = q;
  assign r_res = a_fx[WIDTH-1:0];
  assign dvd = q;
`endif
  nrdiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .start(start), .m_zero(m_zero),
    .load(load), .load_m(load_m), .shift(shift), .fix(fix),
    .busy(busy), .done(done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        q           <= din_abs;
        a           <= '0;
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end
      if (load_m) begin
        m <= {1'b0, din_abs};
        if (m_zero) begin
          quotient    <= '1;
          remainder   <= dvd;
          div_by_zero <= 1'b1;
        end
      end
      if (shift) begin
        a <= a_nx;
        q <= {q[WIDTH-2:0], ~a_nx[WIDTH]};
      end
      if (fix) begin
        a         <= a_fx;
        quotient  <= q_res;
        remainder <= r_res;
      end
    end
  end
endmodule

// File: tb/tb_nrdiv_top.sv
// tb_nrdiv_top: scoreboard bench for nrdiv_top with directed divide vectors
module tb_nrdiv_top;
  localparam int W = 16;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  exp_t sb[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  nrdiv_top #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end
  task automatic op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                    input logic [W-1:0] eq, input logic [W-1:0] er,
                    input logic edz, input bit poke);
    bit seen = 0;
    @(negedge clk);
    start = 1'b1;
    data_in = dd;
    sb.push_back('{q: eq, r: er, dz: edz, cyc: cyc + (edz ? 2 : W + 3)});
    @(negedge clk);
    start = 1'b0;
    data_in = dv;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      data_in = W'($urandom);
      start = poke && i == 4;
      seen = done;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 0);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 0);
    op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 0);
    op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);
    op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 0);
    op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 1);
    op(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 0);
    op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 0);
`ifdef NRDIV_SIGNED_EN
    op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 0);
    op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 0);
    op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 0);
    op(16'hFFFB, 16'd0, 16'hFFFF, 16'hFFFB, 1'b1, 0);
`else
    op(16'h8000, 16'd3, 16'd10922, 16'd2, 1'b0, 0);
`endif
    @(negedge clk);
    start = 1'b1;
    data_in = 16'd200;
    @(negedge clk);
    start = 1'b0;
    data_in = 16'd7;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
